// File: rtl/inv_shift_rows_seq.sv
// inv_shift_rows_seq: sequential AES InvShiftRows stage for the decrypt datapath.
// Accepts one state block on a valid/ready handshake, then rotates one row per
// clock (row r rotated right by r elements) and holds the result on a
// valid/ready output until the next stage takes it.
// The state is a DIMENSION x DIMENSION byte matrix in column-major order, and
// s(0,0) is the most significant byte.
// Optional build macro SHIFTROWS_FWD_EN adds a 'mode' input. With mode=1 the
// block applies forward ShiftRows (row r rotated left by r). mode is sampled
// only when a block is accepted.
module inv_shift_rows_seq #(
  parameter  int DIMENSION = 4,
  parameter  int BYTE_W    = 8,
  localparam int STATE_W   = DIMENSION * DIMENSION * BYTE_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_data,
`ifdef SHIFTROWS_FWD_EN
  input  logic               mode,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data,
  output logic               busy
);

  localparam int CNT_W = (DIMENSION > 1) ? $clog2(DIMENSION) : 1;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(DIMENSION - 1);
  localparam logic [CNT_W-1:0] FIRST_ROW = CNT_W'(1);
  // A 1x1 state has nothing to rotate, so the block goes straight to DONE.
  localparam bit NO_SHIFT = (DIMENSION < 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_reg;
  logic [STATE_W-1:0] work_reg;
  logic [CNT_W-1:0]   row_cnt_reg;
  logic               out_valid_reg;
  logic               busy_reg;
  logic               in_ready_reg;
`ifdef SHIFTROWS_FWD_EN
  logic               mode_reg;
`endif

  // Work register with the row selected by row_cnt_reg rotated; other rows held.
  logic [STATE_W-1:0] shift_next;

  genvar gi, gc;
  generate
    for (gi = 0; gi < DIMENSION; gi++) begin : g_row
      for (gc = 0; gc < DIMENSION; gc++) begin : g_col
        // Bit position of element (gi, gc) in the packed state.
        localparam int POS = STATE_W - 1 - BYTE_W * (DIMENSION * gc + gi);
        // Inverse: out(r,c) = in(r, c-r), which is a rotate right by r.
        localparam int INV_SRC_C = (gc + DIMENSION - gi) % DIMENSION;
        localparam int INV_POS = STATE_W - 1 - BYTE_W * (DIMENSION * INV_SRC_C + gi);
        logic [BYTE_W-1:0] rot_byte;
`ifdef SHIFTROWS_FWD_EN
        // Forward: out(r,c) = in(r, c+r), which is a rotate left by r.
        localparam int FWD_SRC_C = (gc + gi) % DIMENSION;
        localparam int FWD_POS = STATE_W - 1 - BYTE_W * (DIMENSION * FWD_SRC_C + gi);
        assign rot_byte = mode_reg ? work_reg[FWD_POS -: BYTE_W]
                                   : work_reg[INV_POS -: BYTE_W];
`else
        assign rot_byte = work_reg[INV_POS -: BYTE_W];
`endif
        assign shift_next[POS -: BYTE_W] =
          (row_cnt_reg == CNT_W'(gi)) ? rot_byte : work_reg[POS -: BYTE_W];
      end
    end
  endgenerate

  // Control FSM plus datapath: load on accept, rotate one row per cycle, hold the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      work_reg      <= '0;
      row_cnt_reg   <= '0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      in_ready_reg  <= 1'b1;
`ifdef SHIFTROWS_FWD_EN
      mode_reg      <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready_reg) begin
            work_reg      <= in_data;
            row_cnt_reg   <= FIRST_ROW;
            in_ready_reg  <= 1'b0;
            busy_reg      <= 1'b1;
            out_valid_reg <= NO_SHIFT;
            state_reg     <= NO_SHIFT ? DONE : SHIFT;
`ifdef SHIFTROWS_FWD_EN
            mode_reg      <= mode;
`endif
          end
        end
        SHIFT: begin
          work_reg    <= shift_next;
          row_cnt_reg <= row_cnt_reg + FIRST_ROW;
          if (row_cnt_reg == LAST_ROW) begin
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
          end
        end
        DONE: begin
          // Any in_valid seen here is ignored because in_ready_reg is still low.
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
          in_ready_reg  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  // out_data follows the work register at all times; it is meaningful only while out_valid is high.
  assign out_data  = work_reg;

endmodule
